// File: rtl/sm_step_pkg.sv
// rtl/sm_step_pkg.sv - opcode constants and state encoding for the step controller
package sm_step_pkg;

    localparam logic [1:0] OP_HALT  = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;
    localparam logic [1:0] OP_RUN_N = 2'd3;

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_RUN   = 2'd1,
        S_COUNT = 2'd2
    } state_t;

endpackage

// File: rtl/sm_step_ctrl_if.sv
// rtl/sm_step_ctrl_if.sv - command handshake bundle between host and step controller
interface sm_step_ctrl_if #(
    parameter int CNT_W = 16
);

    logic             cmd_valid;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_count,
        output cmd_ready
    );

endinterface

// File: rtl/sm_step_prescaler.sv
// rtl/sm_step_prescaler.sv - free-running prescaler producing a tick every 2^(SHIFT+divide) clocks
module sm_step_prescaler #(
    parameter int SHIFT = 4,
    parameter int PRE_W = SHIFT + 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] divide,
    input  logic       clear,
    output logic       tick
);

    logic [PRE_W-1:0] r_pre;
    logic [PRE_W-1:0] w_limit;

    // >= rather than == so a live shrink of divide fires on the next cycle instead of wrapping
    always_comb begin
        w_limit = (PRE_W'(1) << (PRE_W'(SHIFT) + PRE_W'(divide))) - PRE_W'(1);
        tick    = (r_pre >= w_limit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (tick || clear) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

endmodule

// File: rtl/sm_step_ctrl.sv
// rtl/sm_step_ctrl.sv - CPU run/step/breakpoint controller issuing prescaled cpu_en pulses
module sm_step_ctrl
    import sm_step_pkg::*;
#(
    parameter int SHIFT = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          divide,
    sm_step_ctrl_if.slave       cmd,
    input  logic                bp_enable,
    input  logic [31:0]         bp_addr,
    input  logic [31:0]         pc,
    output logic                cpu_en,
    output logic                halted,
    output logic                bp_hit,
    output logic [31:0]         pulse_cnt
);

    state_t           r_state,     w_state_nxt;
    logic [CNT_W-1:0] r_rem,       w_rem_nxt;
    logic             r_first,     w_first_nxt;
    logic             r_cpu_en,    w_cpu_en_nxt;
    logic             r_bp_hit,    w_bp_hit_nxt;
    logic [31:0]      r_pulse_cnt, w_pulse_cnt_nxt;

    logic w_accept;
    logic w_tick_raw;
    logic w_tick;
    logic w_bp_match;

    assign cmd.cmd_ready = 1'b1;
    assign w_accept      = cmd.cmd_valid;
    assign w_tick        = w_tick_raw && !w_accept;
    assign w_bp_match    = bp_enable && (pc == bp_addr);

    sm_step_prescaler #(
        .SHIFT (SHIFT),
        .PRE_W (SHIFT + 16)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .divide (divide),
        .clear  (w_accept),
        .tick   (w_tick_raw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_HALT;
            r_rem       <= '0;
            r_first     <= 1'b0;
            r_cpu_en    <= 1'b0;
            r_bp_hit    <= 1'b0;
            r_pulse_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rem       <= w_rem_nxt;
            r_first     <= w_first_nxt;
            r_cpu_en    <= w_cpu_en_nxt;
            r_bp_hit    <= w_bp_hit_nxt;
            r_pulse_cnt <= w_pulse_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rem_nxt       = r_rem;
        w_first_nxt     = r_first;
        w_cpu_en_nxt    = 1'b0;
        w_bp_hit_nxt    = r_bp_hit;
        w_pulse_cnt_nxt = r_pulse_cnt + 32'(r_cpu_en);

        if (w_accept) begin
            w_bp_hit_nxt = 1'b0;
            w_first_nxt  = 1'b1;
            case (cmd.cmd_op)
                OP_HALT: begin
                    w_state_nxt = S_HALT;
                    w_rem_nxt   = '0;
                end
                OP_RUN: begin
                    w_state_nxt = S_RUN;
                end
                OP_STEP: begin
                    w_state_nxt = S_COUNT;
                    w_rem_nxt   = CNT_W'(1);
                end
                default: begin
                    if (cmd.cmd_count == '0) begin
                        w_state_nxt = S_HALT;
                        w_rem_nxt   = '0;
                    end else begin
                        w_state_nxt = S_COUNT;
                        w_rem_nxt   = cmd.cmd_count;
                    end
                end
            endcase
        end else if (w_tick && (r_state != S_HALT)) begin
            // first tick after a command skips the breakpoint so a stopped CPU can resume
            w_first_nxt = 1'b0;
            if (!r_first && w_bp_match) begin
                w_state_nxt  = S_HALT;
                w_bp_hit_nxt = 1'b1;
            end else begin
                w_cpu_en_nxt = 1'b1;
                if (r_state == S_COUNT) begin
                    w_rem_nxt = r_rem - CNT_W'(1);
                    if (r_rem == CNT_W'(1)) begin
                        w_state_nxt = S_HALT;
                    end
                end
            end
        end
    end

    assign cpu_en    = r_cpu_en;
    assign halted    = (r_state == S_HALT);
    assign bp_hit    = r_bp_hit;
    assign pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_sm_step_ctrl.sv
// tb/tb_sm_step_ctrl.sv - directed and randomized bench for sm_step_ctrl against a behavioural model
module tb_sm_step_ctrl;
    import sm_step_pkg::*;

    localparam int SHIFT = 0;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  divide = 4'd0;
    logic        bp_enable = 1'b0;
    logic [31:0] bp_addr = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        cpu_en;
    logic        halted;
    logic        bp_hit;
    logic [31:0] pulse_cnt;

    sm_step_ctrl_if #(.CNT_W(CNT_W)) cmd_if ();

    sm_step_ctrl #(
        .SHIFT (SHIFT),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .divide    (divide),
        .cmd       (cmd_if.slave),
        .bp_enable (bp_enable),
        .bp_addr   (bp_addr),
        .pc        (pc),
        .cpu_en    (cpu_en),
        .halted    (halted),
        .bp_hit    (bp_hit),
        .pulse_cnt (pulse_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // model: mode 0=stopped, 1=free running, 2=counted; m_wait = clocks since prescaler restart
    int          m_mode;
    int unsigned m_left;
    int unsigned m_wait;
    bit          m_fresh;
    bit          m_en;
    bit          m_bp;
    logic [31:0] m_cnt;
    logic [31:0] pc_mark;

    task automatic model_reset();
        m_mode  = 0;
        m_left  = 0;
        m_wait  = 0;
        m_fresh = 0;
        m_en    = 0;
        m_bp    = 0;
        m_cnt   = 0;
        pc_mark = 0;
    endtask

    task automatic model_step(input bit v, input logic [1:0] op, input logic [15:0] cnt);
        int unsigned period;
        bit          due;
        bit          fire;
        period  = 1 << (SHIFT + int'(divide));
        due     = (m_wait + 1 >= period);
        fire    = 0;
        m_cnt   = m_cnt + (m_en ? 32'd1 : 32'd0);
        if (v) begin
            m_bp    = 0;
            m_fresh = 1;
            m_wait  = 0;
            if (op == OP_HALT) m_mode = 0;
            else if (op == OP_RUN) m_mode = 1;
            else if (op == OP_STEP) begin m_mode = 2; m_left = 1; end
            else if (cnt == 0) m_mode = 0;
            else begin m_mode = 2; m_left = cnt; end
        end else if (due) begin
            m_wait = 0;
            if (m_mode != 0) begin
                if (!m_fresh && bp_enable && pc == bp_addr) begin
                    m_mode = 0;
                    m_bp   = 1;
                end else begin
                    fire = 1;
                    if (m_mode == 2) begin
                        m_left--;
                        if (m_left == 0) m_mode = 0;
                    end
                end
                m_fresh = 0;
            end
        end else begin
            m_wait++;
        end
        m_en = fire;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".cpu_en"},    32'(cpu_en),           32'(m_en));
        chk({tag, ".halted"},    32'(halted),           32'(m_mode == 0));
        chk({tag, ".bp_hit"},    32'(bp_hit),           32'(m_bp));
        chk({tag, ".pulse_cnt"}, pulse_cnt,             m_cnt);
        chk({tag, ".ready"},     32'(cmd_if.cmd_ready), 32'd1);
    endtask

    // one clock: drive at negedge, predict, then compare at the next negedge
    task automatic cyc(input string tag, input bit v, input logic [1:0] op, input logic [15:0] cnt);
        pc                 = (m_cnt - pc_mark) << 2;
        cmd_if.cmd_valid   = v;
        cmd_if.cmd_op      = op;
        cmd_if.cmd_count   = cnt;
        model_step(v, op, cnt);
        @(negedge clk);
        check_all(tag);
        cmd_if.cmd_valid   = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, OP_HALT, 16'd0);
    endtask

    initial begin
        int guard;
        logic [31:0] snap;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_HALT;
        cmd_if.cmd_count = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        idle("halt_idle", 4);

        divide = 4'd0;
        cyc("step", 1'b1, OP_STEP, 16'd0);
        idle("step", 5);
        chk("step_total", pulse_cnt, 32'd1);
        chk("step_halted", 32'(halted), 32'd1);

        divide = 4'd2;
        cyc("run_n5", 1'b1, OP_RUN_N, 16'd5);
        idle("run_n5", 24);
        chk("run_n5_total", pulse_cnt, 32'd6);
        chk("run_n5_halted", 32'(halted), 32'd1);

        divide    = 4'd1;
        bp_enable = 1'b1;
        bp_addr   = 32'h10;
        pc_mark   = m_cnt;
        cyc("bp_run", 1'b1, OP_RUN, 16'd0);
        idle("bp_run", 20);
        chk("bp_total", pulse_cnt, 32'd10);
        chk("bp_flag", 32'(bp_hit), 32'd1);
        cyc("bp_resume", 1'b1, OP_STEP, 16'd0);
        idle("bp_resume", 6);
        chk("resume_total", pulse_cnt, 32'd11);
        chk("resume_flag", 32'(bp_hit), 32'd0);
        bp_enable = 1'b0;

        divide = 4'd2;
        cyc("halt_tick", 1'b1, OP_RUN, 16'd0);
        idle("halt_tick", 8);
        guard = 0;
        while (m_wait + 1 < 4 && guard < 20) begin
            idle("halt_tick", 1);
            guard++;
        end
        chk("halt_tick_bound", 32'(guard < 20), 32'd1);
        cyc("halt_tick_cmd", 1'b1, OP_HALT, 16'd0);
        chk("halt_tick_no_pulse", 32'(cpu_en), 32'd0);
        chk("halt_tick_halted", 32'(halted), 32'd1);
        idle("halt_tick_after", 6);

        snap = m_cnt;
        cyc("run_n0", 1'b1, OP_RUN_N, 16'd0);
        idle("run_n0", 10);
        chk("run_n0_total", pulse_cnt, snap);

        divide = 4'd3;
        cyc("live_div", 1'b1, OP_RUN, 16'd0);
        idle("live_div", 5);
        divide = 4'd0;
        idle("live_div", 6);
        divide = 4'd2;
        idle("live_div", 9);
        cyc("live_div_halt", 1'b1, OP_HALT, 16'd0);

        divide = 4'd0;
        cyc("rst_mid", 1'b1, OP_RUN_N, 16'd100);
        idle("rst_mid", 15);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_cpu_en",    32'(cpu_en), 32'd0);
        chk("rst_halted",    32'(halted), 32'd1);
        chk("rst_bp_hit",    32'(bp_hit), 32'd0);
        chk("rst_pulse_cnt", pulse_cnt,   32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle("post_rst", 12);
        chk("post_rst_total", pulse_cnt, 32'd0);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 29) == 0) divide = 4'($urandom_range(0, 2));
            if ($urandom_range(0, 19) == 0) bp_enable = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) bp_addr = 32'($urandom_range(0, 7)) << 2;
            if ($urandom_range(0, 39) == 0) pc_mark = m_cnt;
            if ($urandom_range(0, 11) == 0)
                cyc("rand", 1'b1, 2'($urandom_range(0, 3)), 16'($urandom_range(0, 6)));
            else
                idle("rand", 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
